// File: rtl/pwm_pkg.sv
// Shared register addresses, counting-mode type and helpers for the multichannel PWM.
package pwm_pkg;

    localparam logic [6:0] PWM_ADDR_PRESC = 7'h7E;
    localparam logic [6:0] PWM_ADDR_MODE  = 7'h7F;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    // All-ones value for a counter/duty of res_bits width (valid up to 64 bits).
    function automatic logic [63:0] duty_full(input int unsigned res_bits);
        return (64'd1 << res_bits) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter (edge or up/down), wrap and period_start.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int RES_BITS   = 8,
    parameter int PRESC_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESC_BITS-1:0] presc,
    input  logic                  presc_wr,
    input  pwm_mode_e             mode_req,
    output logic [RES_BITS-1:0]   cnt,
    output logic                  wrap,
    output logic                  period_start
);

    localparam logic [RES_BITS-1:0] CNT_MAX = RES_BITS'(duty_full(RES_BITS));
    localparam logic [RES_BITS-1:0] CNT_ONE = RES_BITS'(1);

    logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
    logic [RES_BITS-1:0]   cnt_q, cnt_d;
    logic                  down_q, down_d;
    pwm_mode_e             mode_q, mode_d;
    logic                  period_start_q, period_start_d;
    logic                  tick;

    always_comb begin
        tick        = (presc_cnt_q == presc);
        presc_cnt_d = (presc_wr || tick) ? '0 : presc_cnt_q + 1'b1;
        cnt_d       = cnt_q;
        down_d      = down_q;
        if (tick) begin
            if (mode_q == CENTER && (down_q || cnt_q == CNT_MAX)) begin
                // Turn at the top without repeating it; turn back up once 0 is reached.
                cnt_d  = cnt_q - CNT_ONE;
                down_d = (cnt_d != '0);
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        wrap           = tick && (cnt_d == '0);
        mode_d         = wrap ? mode_req : mode_q;
        period_start_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q    <= '0;
            cnt_q          <= '0;
            down_q         <= 1'b0;
            mode_q         <= EDGE;
            period_start_q <= 1'b0;
        end else begin
            presc_cnt_q    <= presc_cnt_d;
            cnt_q          <= cnt_d;
            down_q         <= down_d;
            mode_q         <= mode_d;
            period_start_q <= period_start_d;
        end
    end

    assign cnt          = cnt_q;
    assign period_start = period_start_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: register file, double-buffered duties and per-channel compare.
// Optional PWM_CENTER_ALIGN_EN adds the mode register (0x7F) for up/down counting.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int RES_BITS   = 8,
    parameter int PRESC_BITS = 8,
    parameter int ADDR_W     = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [RES_BITS-1:0] wr_data,
    input  logic [NUM_CH-1:0]   en_out,
    input  logic [NUM_CH-1:0]   en_pwm,
    output logic [NUM_CH-1:0]   out,
    output logic                period_start
);

    localparam logic [RES_BITS-1:0] DUTY_FULL = RES_BITS'(duty_full(RES_BITS));

    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic                  presc_wr;
    logic [RES_BITS-1:0]   duty_shadow_q [NUM_CH];
    logic [RES_BITS-1:0]   duty_shadow_d [NUM_CH];
    logic [RES_BITS-1:0]   duty_active_q [NUM_CH];
    logic [RES_BITS-1:0]   duty_active_d [NUM_CH];
    logic [NUM_CH-1:0]     out_q, out_d, pwm;
    logic [RES_BITS-1:0]   cnt;
    logic                  wrap;
    pwm_mode_e             mode_req;

`ifdef PWM_CENTER_ALIGN_EN
    pwm_mode_e mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (wr_en && wr_addr == ADDR_W'(PWM_ADDR_MODE)) begin
            mode_d = pwm_mode_e'(wr_data[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= EDGE;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode_req = mode_q;
`else
    assign mode_req = EDGE;
`endif

    always_comb begin
        presc_wr = wr_en && (wr_addr == ADDR_W'(PWM_ADDR_PRESC));
        presc_d  = presc_wr ? PRESC_BITS'(wr_data) : presc_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_shadow_d[i] = (wr_en && int'(wr_addr) == i) ? wr_data : duty_shadow_q[i];
            // Transfer the pre-edge shadow so a write on the wrap tick waits a full period.
            duty_active_d[i] = wrap ? duty_shadow_q[i] : duty_active_q[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign pwm[g]   = (duty_active_q[g] == DUTY_FULL) ? 1'b1 : (cnt < duty_active_q[g]);
        assign out_d[g] = en_out[g] & (~en_pwm[g] | pwm[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            out_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shadow_q[i] <= '0;
                duty_active_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            out_q   <= out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shadow_q[i] <= duty_shadow_d[i];
                duty_active_q[i] <= duty_active_d[i];
            end
        end
    end

    pwm_timebase #(
        .RES_BITS   (RES_BITS),
        .PRESC_BITS (PRESC_BITS)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .presc        (presc_q),
        .presc_wr     (presc_wr),
        .mode_req     (mode_req),
        .cnt          (cnt),
        .wrap         (wrap),
        .period_start (period_start)
    );

    assign out = out_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: per-period window scoreboard plus directed enable/reset checks.
module tb_pwm_multichannel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_multichannel #(
        .NUM_CH     (16),
        .RES_BITS   (8),
        .PRESC_BITS (8),
        .ADDR_W     (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .out          (out),
        .period_start (period_start)
    );

    typedef struct {
        int id;
        int len;
        int e0;
        int e1;
        int e2;
        int e3;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_armed = 1'b0;

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic push(input int id, input int len, input int e0, input int e1,
                        input int e2, input int e3);
        exp_t e;
        e.id = id; e.len = len; e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3;
        exp_q.push_back(e);
    endtask

    // Monitor: a window opens on a period_start and closes on the next one.
    exp_t cur;
    int   m_len;
    int   m_h [4];

    always @(negedge clk) begin
        if (rst) begin
            mon_armed = 1'b0;
        end else begin
            if (period_start && mon_armed) begin
                check($sformatf("win%0d_len", cur.id), m_len, cur.len);
                check($sformatf("win%0d_ch0_high", cur.id), m_h[0], cur.e0);
                check($sformatf("win%0d_ch1_high", cur.id), m_h[1], cur.e1);
                check($sformatf("win%0d_ch2_high", cur.id), m_h[2], cur.e2);
                check($sformatf("win%0d_ch3_high", cur.id), m_h[3], cur.e3);
                mon_armed = 1'b0;
            end
            if (period_start && !mon_armed && exp_q.size() > 0) begin
                cur       = exp_q.pop_front();
                mon_armed = 1'b1;
                m_len     = 0;
                for (int c = 0; c < 4; c++) m_h[c] = 0;
            end
            if (mon_armed) begin
                m_len++;
                for (int c = 0; c < 4; c++) m_h[c] += int'(out[c]);
            end
        end
    end

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_ps(input string nm, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < budget);
        if (!period_start) begin
            total++;
            bad++;
            $display("FAIL %s: no period_start within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_drained(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || mon_armed) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0 || mon_armed) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard not drained after %0d cycles, %0d left",
                     nm, budget, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        en_out = 16'h0007;
        en_pwm = 16'h000F;
        repeat (3) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_period_start", period_start, 0);
        rst = 1'b0;

        // presc 0: ch0 50%, ch1 0%, ch2 100%, ch3 disabled
        wr(7'h7E, 8'h00);
        wr(7'h00, 8'h80);
        wr(7'h01, 8'h00);
        wr(7'h02, 8'hFF);
        wr(7'h03, 8'h40);
        wait_ps("ps_first", 300, n);
        @(negedge clk);
        push(1, 256, 128, 0, 256, 0);
        push(2, 256, 128, 0, 256, 0);
        push(3, 256, 128, 0, 256, 0);
        wait_drained("drain_basic", 1500);

        // presc 3 stretches every tick to 4 clocks
        wr(7'h7E, 8'h03);
        wr(7'h00, 8'h40);
        wait_ps("ps_presc3", 1100, n);
        @(negedge clk);
        push(4, 1024, 256, 0, 1024, 0);
        push(5, 1024, 256, 0, 1024, 0);
        wait_drained("drain_presc3", 3500);

        // double buffering: mid-period write, then a write on the wrap tick itself
        wr(7'h7E, 8'h00);
        wait_ps("ps_presc0", 1100, n);
        repeat (50) @(negedge clk);
        wr(7'h00, 8'h20);
        push(6, 256, 32, 0, 256, 0);
        push(7, 256, 96, 0, 256, 0);
        repeat (204) @(negedge clk);
        wr(7'h00, 8'h60);
        wait_drained("drain_dbuf", 900);

        // enables act immediately, one clock of output latency
        check("en3_off", out[3], 0);
        en_out[3] = 1'b1;
        en_pwm[3] = 1'b0;
        @(negedge clk);
        check("en3_static_high", out[3], 1);
        en_pwm[3] = 1'b1;
        push(8, 256, 96, 0, 256, 64);
        wait_drained("drain_en3", 700);
        en_out[3] = 1'b0;
        @(negedge clk);
        check("en3_off_again", out[3], 0);

        // reset mid-period
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out", out, 0);
        check("midrst_period_start", period_start, 0);
        rst = 1'b0;
        wait_ps("ps_after_rst", 300, n);
        check("rst_restart_cycles", n, 256);
        check("rst_duties_cleared", out, 0);

`ifdef PWM_CENTER_ALIGN_EN
        wr(7'h7F, 8'h01);
        wr(7'h00, 8'h10);
        wait_ps("ps_center", 300, n);
        @(negedge clk);
        push(9, 510, 31, 0, 0, 0);
        wait_drained("drain_center", 1200);
`else
        // mode register absent: write is ignored, period stays 256
        wr(7'h7F, 8'h01);
        wr(7'h00, 8'h10);
        wait_ps("ps_mode_ignored", 300, n);
        @(negedge clk);
        push(9, 256, 16, 0, 0, 0);
        wait_drained("drain_mode_ignored", 700);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
